// File: rtl/csr_pkg.sv
// Shared constants for the machine-mode CSR file: addresses, op encodings, mstatus masks.
package csr_pkg;

  // Machine-mode CSR addresses
  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;

  // User-level read-only counter aliases
  localparam logic [11:0] CSR_CYCLE     = 12'hC00;
  localparam logic [11:0] CSR_INSTRET   = 12'hC02;
  localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
  localparam logic [11:0] CSR_INSTRETH  = 12'hC82;

  typedef enum logic [1:0] {
    CSR_OP_NONE = 2'b00,
    CSR_OP_RW   = 2'b01,
    CSR_OP_RS   = 2'b10,
    CSR_OP_RC   = 2'b11
  } csr_op_e;

  // mstatus: only MIE (bit 3) and MPIE (bit 7) are stored; MPP reads as M-mode
  localparam logic [31:0] MSTATUS_WMASK  = 32'h0000_0088;
  localparam logic [31:0] MSTATUS_RCONST = 32'h0000_1800;

  // Map the 0xCxx read-only aliases onto their 0xBxx machine counterparts
  function automatic logic [11:0] csr_alias_norm(input logic [11:0] addr);
    return (addr[11:8] == 4'hC) ? {4'hB, addr[7:0]} : addr;
  endfunction

endpackage

// File: rtl/csr_counter64.sv
// 64-bit counter built from two 32-bit halves with independent CSR write ports.
// A write to a half overrides the increment for that half; writing the low half
// suppresses the carry into the high half, writing the high half discards it.
module csr_counter64 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc_i,
  input  logic        wr_lo_i,
  input  logic        wr_hi_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] lo_o,
  output logic [31:0] hi_o
);

  logic [31:0] lo_q, lo_d;
  logic [31:0] hi_q, hi_d;
  logic [32:0] lo_sum;

  // Next-state: increment with carry, CSR writes take precedence per half
  always_comb begin
    lo_sum = {1'b0, lo_q} + {32'd0, inc_i};
    lo_d   = wr_lo_i ? wdata_i : lo_sum[31:0];
    if (wr_hi_i) begin
      hi_d = wdata_i;
    end else if (wr_lo_i) begin
      hi_d = hi_q;
    end else begin
      hi_d = hi_q + {31'd0, lo_sum[32]};
    end
  end

  // Counter state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lo_q <= 32'd0;
      hi_q <= 32'd0;
    end else begin
      lo_q <= lo_d;
      hi_q <= hi_d;
    end
  end

  assign lo_o = lo_q;
  assign hi_o = hi_q;

endmodule

// File: rtl/csr_file_wb.sv
// Machine-mode CSR file committed from the WB stage, with a forwarded
// combinational read port for EX and the mcycle/minstret counters.
module csr_file_wb
  import csr_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            csr_write_en_wb,
  input  logic [11:0]     csr_addr_wb,
  input  logic [1:0]      csr_op_wb,
  input  logic [XLEN-1:0] csr_src_wb,
  input  logic            instr_retire_wb,
  input  logic [11:0]     csr_raddr_ex,
  output logic [XLEN-1:0] csr_rdata_ex,
  output logic            csr_err_wb
);

  logic [31:0] mstatus_q, mstatus_d;
  logic [31:0] mie_q, mie_d;
  logic [31:0] mtvec_q, mtvec_d;
  logic [31:0] mscratch_q, mscratch_d;
  logic [31:0] mepc_q, mepc_d;
  logic [31:0] mcause_q, mcause_d;
  logic        err_q, err_d;

  logic [31:0] mcycle_lo, mcycle_hi;
  logic [31:0] minstret_lo, minstret_hi;

  logic        commit;
  logic        wr_legal;
  logic        do_wr;
  logic [31:0] old_val;
  logic [31:0] rmw_val;
  logic [31:0] wr_val;

  // Architectural read value of a CSR, with read masks applied
  function automatic logic [31:0] rd_mux(input logic [11:0] addr);
    case (addr)
      CSR_MSTATUS:              return (mstatus_q & MSTATUS_WMASK) | MSTATUS_RCONST;
      CSR_MIE:                  return mie_q;
      CSR_MTVEC:                return {mtvec_q[31:2], 2'b00};
      CSR_MSCRATCH:             return mscratch_q;
      CSR_MEPC:                 return {mepc_q[31:2], 2'b00};
      CSR_MCAUSE:               return mcause_q;
      CSR_MCYCLE, CSR_CYCLE:    return mcycle_lo;
      CSR_MCYCLEH, CSR_CYCLEH:  return mcycle_hi;
      CSR_MINSTRET, CSR_INSTRET: return minstret_lo;
      CSR_MINSTRETH, CSR_INSTRETH: return minstret_hi;
      default:                  return 32'd0;
    endcase
  endfunction

  // Writable addresses; the 0xCxx aliases and unimplemented CSRs are not
  function automatic logic is_writable(input logic [11:0] addr);
    case (addr)
      CSR_MSTATUS, CSR_MIE, CSR_MTVEC, CSR_MSCRATCH, CSR_MEPC, CSR_MCAUSE,
      CSR_MCYCLE, CSR_MCYCLEH, CSR_MINSTRET, CSR_MINSTRETH: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Read-modify-write of the WB-stage CSR and its write mask
  always_comb begin
    commit   = csr_write_en_wb && (csr_op_wb != CSR_OP_NONE);
    wr_legal = is_writable(csr_addr_wb);
    do_wr    = commit && wr_legal;
    err_d    = commit && !wr_legal;
    old_val  = rd_mux(csr_addr_wb);
    case (csr_op_e'(csr_op_wb))
      CSR_OP_RW: rmw_val = csr_src_wb;
      CSR_OP_RS: rmw_val = old_val | csr_src_wb;
      CSR_OP_RC: rmw_val = old_val & ~csr_src_wb;
      default:   rmw_val = old_val;
    endcase
    case (csr_addr_wb)
      CSR_MSTATUS:          wr_val = (rmw_val & MSTATUS_WMASK) | MSTATUS_RCONST;
      CSR_MTVEC, CSR_MEPC:  wr_val = rmw_val & ~32'h3;
      default:              wr_val = rmw_val;
    endcase
  end

  // Next-state for the plain CSRs
  always_comb begin
    mstatus_d  = mstatus_q;
    mie_d      = mie_q;
    mtvec_d    = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    if (do_wr) begin
      case (csr_addr_wb)
        CSR_MSTATUS:  mstatus_d  = wr_val & MSTATUS_WMASK;
        CSR_MIE:      mie_d      = wr_val;
        CSR_MTVEC:    mtvec_d    = wr_val;
        CSR_MSCRATCH: mscratch_d = wr_val;
        CSR_MEPC:     mepc_d     = wr_val;
        CSR_MCAUSE:   mcause_d   = wr_val;
        default: ;
      endcase
    end
  end

  // EX read port: the value being committed this cycle wins over storage
  always_comb begin
    if (do_wr && (csr_alias_norm(csr_raddr_ex) == csr_addr_wb)) begin
      csr_rdata_ex = wr_val;
    end else begin
      csr_rdata_ex = rd_mux(csr_raddr_ex);
    end
  end

  // CSR storage and error pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mstatus_q  <= 32'd0;
      mie_q      <= 32'd0;
      mtvec_q    <= MTVEC_RESET & ~32'h3;
      mscratch_q <= 32'd0;
      mepc_q     <= 32'd0;
      mcause_q   <= 32'd0;
      err_q      <= 1'b0;
    end else begin
      mstatus_q  <= mstatus_d;
      mie_q      <= mie_d;
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      err_q      <= err_d;
    end
  end

  assign csr_err_wb = err_q;

  csr_counter64 u_mcycle (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc_i   (1'b1),
    .wr_lo_i (do_wr && (csr_addr_wb == CSR_MCYCLE)),
    .wr_hi_i (do_wr && (csr_addr_wb == CSR_MCYCLEH)),
    .wdata_i (wr_val),
    .lo_o    (mcycle_lo),
    .hi_o    (mcycle_hi)
  );

  csr_counter64 u_minstret (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc_i   (instr_retire_wb),
    .wr_lo_i (do_wr && (csr_addr_wb == CSR_MINSTRET)),
    .wr_hi_i (do_wr && (csr_addr_wb == CSR_MINSTRETH)),
    .wdata_i (wr_val),
    .lo_o    (minstret_lo),
    .hi_o    (minstret_hi)
  );

endmodule

// File: tb/tb_csr_file_wb.sv
// Bench for csr_file_wb: directed scenarios then random traffic, all checked
// against an architectural model of the CSRs held as plain variables.
module tb_csr_file_wb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        csr_write_en_wb;
  logic [11:0] csr_addr_wb;
  logic [1:0]  csr_op_wb;
  logic [31:0] csr_src_wb;
  logic        instr_retire_wb;
  logic [11:0] csr_raddr_ex;
  logic [31:0] csr_rdata_ex;
  logic        csr_err_wb;

  int checks   = 0;
  int failures = 0;

  // Model state
  longint unsigned m_cyc, m_ret;
  logic [31:0] m_mstatus, m_mie, m_mtvec, m_mscratch, m_mepc, m_mcause;
  bit          m_err;

  logic [11:0] addr_pool [16] = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
                                  12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hC00, 12'hC80,
                                  12'hC02, 12'hC82, 12'h7C0, 12'h301};

  always #5 clk = ~clk;

  csr_file_wb dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .csr_write_en_wb (csr_write_en_wb),
    .csr_addr_wb     (csr_addr_wb),
    .csr_op_wb       (csr_op_wb),
    .csr_src_wb      (csr_src_wb),
    .instr_retire_wb (instr_retire_wb),
    .csr_raddr_ex    (csr_raddr_ex),
    .csr_rdata_ex    (csr_rdata_ex),
    .csr_err_wb      (csr_err_wb)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cyc = 0; m_ret = 0;
    m_mstatus = 32'h0000_1800; m_mie = 0; m_mtvec = 0;
    m_mscratch = 0; m_mepc = 0; m_mcause = 0; m_err = 0;
  endtask

  function automatic logic [31:0] m_read(input logic [11:0] a);
    case (a)
      12'h300: return m_mstatus;
      12'h304: return m_mie;
      12'h305: return m_mtvec;
      12'h340: return m_mscratch;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'hB00, 12'hC00: return m_cyc[31:0];
      12'hB80, 12'hC80: return m_cyc[63:32];
      12'hB02, 12'hC02: return m_ret[31:0];
      12'hB82, 12'hC82: return m_ret[63:32];
      default: return 32'd0;
    endcase
  endfunction

  function automatic bit m_legal(input logic [11:0] a);
    return a inside {12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
                     12'hB00, 12'hB80, 12'hB02, 12'hB82};
  endfunction

  function automatic logic [31:0] m_new(input logic [11:0] a, input logic [1:0] op,
                                        input logic [31:0] src);
    logic [31:0] v;
    case (op)
      2'b01:   v = src;
      2'b10:   v = m_read(a) | src;
      2'b11:   v = m_read(a) & ~src;
      default: v = m_read(a);
    endcase
    if (a == 12'h300) v = (v & 32'h88) | 32'h1800;
    else if (a == 12'h305 || a == 12'h341) v = v & ~32'h3;
    return v;
  endfunction

  function automatic logic [11:0] m_norm(input logic [11:0] a);
    return (a[11:8] == 4'hC) ? {4'hB, a[7:0]} : a;
  endfunction

  // One clock cycle: drive WB/EX inputs, check read port and error flag, clock, update model.
  // Entered and left 1 time unit after a rising edge.
  task automatic step(input bit we, input logic [11:0] a, input logic [1:0] op,
                      input logic [31:0] src, input bit ret, input logic [11:0] ra);
    logic [31:0] nv, exp;
    longint unsigned ncyc, nret;
    bit commit, lg;
    csr_write_en_wb = we; csr_addr_wb = a; csr_op_wb = op; csr_src_wb = src;
    instr_retire_wb = ret; csr_raddr_ex = ra;
    #2;
    commit = we && (op != 2'b00);
    lg     = m_legal(a);
    nv     = m_new(a, op, src);
    exp    = (commit && lg && m_norm(ra) == a) ? nv : m_read(ra);
    check($sformatf("rdata@%h", ra), csr_rdata_ex, exp);
    check("err", {31'd0, csr_err_wb}, {31'd0, m_err});
    @(posedge clk);
    ncyc = m_cyc + 1;
    nret = m_ret + (ret ? 1 : 0);
    if (commit && lg) begin
      case (a)
        12'h300: m_mstatus  = nv;
        12'h304: m_mie      = nv;
        12'h305: m_mtvec    = nv;
        12'h340: m_mscratch = nv;
        12'h341: m_mepc     = nv;
        12'h342: m_mcause   = nv;
        12'hB00: ncyc = {m_cyc[63:32], nv};
        12'hB80: ncyc = {nv, m_cyc[31:0] + 32'd1};
        12'hB02: nret = {m_ret[63:32], nv};
        12'hB82: nret = {nv, m_ret[31:0] + (ret ? 32'd1 : 32'd0)};
        default: ;
      endcase
    end
    m_cyc = ncyc;
    m_ret = nret;
    m_err = commit && !lg;
    #1;
    csr_write_en_wb = 1'b0; csr_op_wb = 2'b00; instr_retire_wb = 1'b0;
  endtask

  // Direct read of the EX port with no write in flight
  task automatic peek(input string tag, input logic [11:0] ra, input logic [31:0] exp);
    csr_raddr_ex = ra;
    #1;
    check(tag, csr_rdata_ex, exp);
  endtask

  initial begin
    csr_write_en_wb = 0; csr_addr_wb = 0; csr_op_wb = 0; csr_src_wb = 0;
    instr_retire_wb = 0; csr_raddr_ex = 12'h300;
    rst_n = 1'b0;
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    // Idle after reset
    for (int i = 0; i < 10; i++) step(0, 12'h000, 2'b00, 0, 0, 12'h300);
    peek("mcycle_after_10", 12'hB00, 32'd10);
    peek("mcycleh_after_10", 12'hB80, 32'd0);
    peek("mstatus_reset", 12'h300, 32'h0000_1800);

    // mscratch forwarding and RC
    step(1, 12'h340, 2'b01, 32'hDEADBEEF, 0, 12'h340);
    step(1, 12'h340, 2'b11, 32'h0000FFFF, 0, 12'h340);
    peek("mscratch_rc", 12'h340, 32'hDEAD0000);

    // Write masks
    step(1, 12'h300, 2'b01, 32'hFFFFFFFF, 0, 12'h300);
    peek("mstatus_mask", 12'h300, 32'h0000_1888);
    step(1, 12'h305, 2'b01, 32'h12345677, 0, 12'h305);
    peek("mtvec_mask", 12'h305, 32'h12345674);

    // Counter carry and write-high precedence
    step(1, 12'hB80, 2'b01, 32'd0, 0, 12'hB80);
    step(1, 12'hB00, 2'b01, 32'hFFFFFFFF, 0, 12'hB00);
    step(0, 12'h000, 2'b00, 0, 0, 12'hC00);
    peek("mcycleh_carry", 12'hB80, 32'd1);
    peek("mcycle_wrap", 12'hB00, 32'd0);
    step(1, 12'hB80, 2'b01, 32'd0, 0, 12'hB80);
    step(1, 12'hB00, 2'b01, 32'hFFFFFFFF, 0, 12'hB80);
    step(1, 12'hB80, 2'b01, 32'd5, 0, 12'hC80);
    peek("mcycleh_write_wins", 12'hB80, 32'd5);
    peek("mcycle_wrap2", 12'hB00, 32'd0);

    // Illegal writes: read-only alias and unimplemented address
    step(1, 12'hC00, 2'b01, 32'd1, 0, 12'hC00);
    check("err_pulse_c00", {31'd0, csr_err_wb}, 32'd1);
    step(0, 12'h000, 2'b00, 0, 0, 12'h340);
    check("err_clear_c00", {31'd0, csr_err_wb}, 32'd0);
    step(1, 12'h7C0, 2'b10, 32'd1, 0, 12'h7C0);
    check("err_pulse_7c0", {31'd0, csr_err_wb}, 32'd1);
    peek("unimpl_read", 12'h7C0, 32'd0);
    step(0, 12'h000, 2'b00, 0, 0, 12'h340);
    check("err_clear_7c0", {31'd0, csr_err_wb}, 32'd0);

    // minstret: retire every cycle, write 100 on the 4th
    step(1, 12'hB82, 2'b01, 32'd0, 0, 12'hB82);
    step(1, 12'hB02, 2'b01, 32'd0, 0, 12'hB02);
    for (int i = 1; i <= 7; i++) step(i == 4, 12'hB02, 2'b01, 32'd100, 1, 12'hC02);
    peek("minstret_103", 12'hB02, 32'd103);

    // Asynchronous reset mid-sequence
    step(0, 12'h000, 2'b00, 0, 1, 12'hB02);
    step(1, 12'h340, 2'b01, 32'h55AA55AA, 1, 12'hB02);
    rst_n = 1'b0;
    #1;
    peek("rst_mcycle", 12'hB00, 32'd0);
    peek("rst_minstret", 12'hB02, 32'd0);
    peek("rst_mscratch", 12'h340, 32'd0);
    check("rst_err", {31'd0, csr_err_wb}, 32'd0);
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    step(0, 12'h000, 2'b00, 0, 0, 12'hB00);
    peek("mcycle_after_rst", 12'hC00, 32'd1);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      logic [11:0] a, ra;
      logic [31:0] src;
      a   = addr_pool[$urandom_range(0, 15)];
      ra  = ($urandom_range(0, 3) == 0) ? a : addr_pool[$urandom_range(0, 15)];
      src = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFF : $urandom;
      step($urandom_range(0, 1) == 1, a, 2'($urandom_range(0, 3)), src,
           $urandom_range(0, 1) == 1, ra);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/csr_file_wb.md
# csr_file_wb

Machine-mode CSR register file sitting directly downstream of the MEM/WB control segment register: it consumes the registered CSR write enable of the WB stage and commits CSR read-modify-write results at the WB clock edge. It also provides a combinational read port to the EX stage, with WB-to-EX forwarding, and maintains the 64-bit cycle and retired-instruction counters. The block contains all architectural CSR state of the core.

## Interface
Parameters:
- XLEN, 32, CSR data width; only 32 is supported.
- MTVEC_RESET, 32'h0000_0000, reset value of mtvec; bits [1:0] are ignored.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- csr_write_en_wb  in  1  CSR write enable from the MEM/WB segment; already zero when WB is flushed.
- csr_addr_wb  in  12  CSR address of the instruction in WB.
- csr_op_wb  in  2  operation: 01 RW, 10 RS, 11 RC, 00 none (no write).
- csr_src_wb  in  XLEN  rs1 value, or zimm zero-extended to 32 bits.
- instr_retire_wb  in  1  a valid instruction retires this cycle.
- csr_raddr_ex  in  12  EX-stage read address.
- csr_rdata_ex  out  XLEN  combinational read data, forwarded.
- csr_err_wb  out  1  registered one-cycle pulse: the previous cycle attempted an illegal CSR write.

## Operation
- Implemented CSRs:
  - mstatus 0x300: MIE bit 3 and MPIE bit 7 are writable; MPP [12:11] reads 2'b11; all other bits read 0.
  - mie 0x304: full 32-bit register.
  - mtvec 0x305: bits [1:0] read 0 (direct mode only).
  - mscratch 0x340: full 32-bit register.
  - mepc 0x341: bits [1:0] read 0.
  - mcause 0x342: full 32-bit register.
  - mcycle 0xB00 and mcycleh 0xB80: read/write.
  - minstret 0xB02 and minstreth 0xB82: read/write.
  - cycle 0xC00, instret 0xC02, cycleh 0xC80, instreth 0xC82: read-only aliases of the machine counters.
- Write data: old = current value through the read mask; RW → src; RS → old | src; RC → old & ~src. The result is then stored through the write mask.
- Commit condition: csr_write_en_wb=1 and csr_op_wb≠00.
- An RS or RC with src=0 still counts as a write; no special-casing.
- An illegal write (address in 0xC00–0xCFF, or unimplemented) does not change any state. csr_err_wb goes to 1 for exactly the next cycle.
- Reads of unimplemented addresses return 0 and do not raise an error.
- Read port returns the current stored value, except when csr_write_en_wb=1, csr_op_wb≠00, and the (alias-normalised) address matches csr_raddr_ex; then it returns the masked new value.
- Alias normalisation maps 0xCxx to 0xBxx for the match only.
- Counters:
  - mcycle increments by 1 every cycle when not in reset.
  - minstret increments by 1 when instr_retire_wb=1.
  - Both are full 64-bit with carry from low to high; wrap from all-ones to 0.
  - A CSR write to a counter half wins over the increment for that half in that cycle.
  - Write to the low half: the high half gets no carry that cycle.
  - Write to the high half: the low half still increments; any carry from that increment is discarded.
  - The instruction that writes minstret does not itself increment it.

## Timing
- Reset (rst_n=0, asynchronous) values:
  - All registers 0, except mtvec = MTVEC_RESET & ~3.
  - mstatus reads 32'h0000_1800.
  - csr_err_wb = 0.
- Write latency: the new value is visible in storage after the rising edge of the commit cycle, and to EX in the same cycle through forwarding.
- Counter reads return the pre-edge value; mcycle read in cycle N after reset release returns N.
- Reset asserted mid-operation clears all state immediately. The first increment occurs on the first rising edge with rst_n=1.
- No stall or handshake: the block accepts one write per cycle unconditionally.

## Structure
- Package csr_pkg holds:
  - 12-bit address constants for every CSR listed above;
  - op encodings CSR_OP_NONE, CSR_OP_RW, CSR_OP_RS, CSR_OP_RC;
  - the mstatus write mask 32'h0000_0088 and read constant 32'h0000_1800.
- Sub-module csr_counter64, instantiated twice, contains:
  - a 64-bit register with inc input;
  - wr_lo and wr_hi inputs with a 32-bit wdata;
  - lo and hi outputs;
  - the precedence rules above.
- The top level holds the address decode, RMW logic, forwarding mux and error flag.

## Test plan
- Reset release, then idle 10 cycles → reading 0xB00 returns 10, 0xB80 returns 0, 0x300 returns 32'h1800, csr_err_wb=0 throughout.
- RW 0x340 with src 0xDEADBEEF, csr_raddr_ex=0x340 in the same cycle → csr_rdata_ex=0xDEADBEEF combinationally. Then RC with src 0x0000FFFF → stored value 0xDEAD0000.
- RW 0x300 with src 0xFFFFFFFF → reads 0x00001888; RW 0x305 with src 0x12345677 → reads 0x12345674.
- RW mcycle=0xFFFFFFFF and mcycleh=0, idle one cycle → mcycleh=1 and mcycle=0 next cycle. Writing mcycleh=5 in the same cycle as a low-half wrap → mcycleh=5.
- RW 0xC00 with src 1 → no state change, csr_err_wb=1 for exactly one cycle. Write to 0x7C0 → same behaviour.
- Toggle instr_retire_wb for 7 cycles, with a minstret write of 100 in the 4th of those cycles → minstret=103 afterwards; assert rst_n low mid-sequence → all counters 0 immediately.
